// File: rtl/hamming16t11d_pkg.sv
// Shared constants and types for the 16t11d SECDED storage slice.
//   DATA_W / CODE_W / N_CHECKB : data, codeword and Hamming check-bit widths
//   code_t / data_t            : codeword and data word types
//   DATA_POS                   : codeword position of each data bit
//   dec_status_e               : decoder verdict (clean, corrected, uncorrectable)
package hamming16t11d_pkg;

  localparam int unsigned DATA_W   = 11;
  localparam int unsigned CODE_W   = 16;
  localparam int unsigned N_CHECKB = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DATA_W-1:0] data_t;

  // Non-power-of-two positions, i.e. every slot not taken by a check bit or bit 0.
  localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SEC   = 2'd1,
    DED   = 2'd2
  } dec_status_e;

endpackage

// File: rtl/hamming16t11d_dec.sv
// Combinational 16t11d SECDED decoder.
//   code_i   : stored codeword
//   data_o   : corrected data (uncorrected pass-through on DED)
//   status_o : CLEAN, SEC (single error fixed) or DED (double error detected)
module hamming16t11d_dec
  import hamming16t11d_pkg::*;
(
  input  code_t       code_i,
  output data_t       data_o,
  output dec_status_e status_o
);

  logic [3:0] syndrome;
  logic       parity;
  code_t      corrected;

  always_comb begin
    syndrome = '0;
    for (int i = 1; i < int'(CODE_W); i++) begin
      if (code_i[4'(i)]) begin
        syndrome = syndrome ^ 4'(i);
      end
    end
    parity    = ^code_i;
    corrected = code_i;
    status_o  = CLEAN;
    if (parity) begin
      // Syndrome 0 with odd parity points at bit 0 itself; data is unaffected.
      corrected[syndrome] = ~code_i[syndrome];
      status_o            = SEC;
    end else if (syndrome != '0) begin
      status_o = DED;
    end
    data_o = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      data_o[4'(i)] = corrected[4'(DATA_POS[i])];
    end
  end

endmodule

// File: rtl/hamming16t11d_enc.sv
// Combinational 11->16 SECDED encoder.
//   data_i : 11-bit data word
//   code_o : 16-bit codeword (bit 0 overall parity, check bits at 1/2/4/8)
module hamming16t11d_enc
  import hamming16t11d_pkg::*;
(
  input  data_t data_i,
  output code_t code_o
);

  code_t code;

  always_comb begin
    code = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      code[4'(DATA_POS[i])] = data_i[4'(i)];
    end
    // Check positions never fall inside another check bit's cover set, so the
    // accumulation below only ever reads data bits (or its own still-zero slot).
    for (int k = 0; k < int'(N_CHECKB); k++) begin
      for (int p = 3; p < int'(CODE_W); p++) begin
        if ((((p >> k) & 1) == 1) && (p != (1 << k))) begin
          code[4'(1 << k)] = code[4'(1 << k)] ^ code[4'(p)];
        end
      end
    end
    code[0] = ^code[CODE_W-1:1];
  end

  assign code_o = code;

endmodule

// File: rtl/hamming16t11d_scrub_mem.sv
// SECDED-protected register file with background scrubber and error counters.
//   we_i/waddr_i/wdata_i/inj_mask_i : write port, mask XORed into the stored codeword
//   re_i/raddr_i -> rdata_o/rvalid_o/rsec_o/rded_o : 1-cycle read port, read-first
//   scrub_en_i/scrub_busy_o          : scrubber enable, busy while in READ or FIX
//   clr_cnt_i/sec_cnt_o/ded_cnt_o    : saturating SEC/DED event counters
//   ded_addr_o                       : address of the most recent DED
module hamming16t11d_scrub_mem
  import hamming16t11d_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned SCRUB_PERIOD = 1024,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [CODE_W-1:0]        inj_mask_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     rvalid_o,
  output logic                     rsec_o,
  output logic                     rded_o,
  input  logic                     scrub_en_i,
  output logic                     scrub_busy_o,
  input  logic                     clr_cnt_i,
  output logic [CNT_W-1:0]         sec_cnt_o,
  output logic [CNT_W-1:0]         ded_cnt_o,
  output logic [$clog2(DEPTH)-1:0] ded_addr_o
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned TimerW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StRead, StFix} scrub_state_e;

  code_t              mem_q [DEPTH];
  code_t              mem_d [DEPTH];
  data_t              rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               rsec_q, rsec_d;
  logic               rded_q, rded_d;
  scrub_state_e       state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [AddrW-1:0]   ptr_q, ptr_d;
  data_t              sc_data_q, sc_data_d;
  dec_status_e        sc_status_q, sc_status_d;
  logic [CNT_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]   ded_cnt_q, ded_cnt_d;
  logic [AddrW-1:0]   ded_addr_q, ded_addr_d;

  code_t       wr_code, wb_code;
  data_t       rd_dec_data, sc_dec_data;
  dec_status_e rd_dec_status, sc_dec_status;
  logic        rd_sec, rd_ded, sc_sec, sc_ded, wb_en;
  logic [1:0]  sec_inc, ded_inc;

  hamming16t11d_enc u_enc_wr (
    .data_i (wdata_i),
    .code_o (wr_code)
  );

  hamming16t11d_enc u_enc_wb (
    .data_i (sc_data_q),
    .code_o (wb_code)
  );

  hamming16t11d_dec u_dec_rd (
    .code_i   (mem_q[raddr_i]),
    .data_o   (rd_dec_data),
    .status_o (rd_dec_status)
  );

  hamming16t11d_dec u_dec_sc (
    .code_i   (mem_q[ptr_q]),
    .data_o   (sc_dec_data),
    .status_o (sc_dec_status)
  );

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    rd_sec  = re_i && (rd_dec_status == SEC);
    rd_ded  = re_i && (rd_dec_status == DED);
    sc_sec  = (state_q == StFix) && (sc_status_q == SEC);
    sc_ded  = (state_q == StFix) && (sc_status_q == DED);
    // A user write to the scrubbed word already carries fresh data, so the repair is dropped.
    wb_en   = sc_sec && !(we_i && (waddr_i == ptr_q));
    sec_inc = {1'b0, rd_sec} + {1'b0, sc_sec};
    ded_inc = {1'b0, rd_ded} + {1'b0, sc_ded};

    mem_d = mem_q;
    if (wb_en) begin
      mem_d[ptr_q] = wb_code;
    end
    if (we_i) begin
      mem_d[waddr_i] = wr_code ^ inj_mask_i;
    end

    rvalid_d = re_i;
    rdata_d  = re_i ? rd_dec_data : rdata_q;
    rsec_d   = rd_sec;
    rded_d   = rd_ded;

    sec_cnt_d = clr_cnt_i ? '0 : sat_add(sec_cnt_q, sec_inc);
    ded_cnt_d = clr_cnt_i ? '0 : sat_add(ded_cnt_q, ded_inc);

    ded_addr_d = ded_addr_q;
    if (rd_ded) begin
      ded_addr_d = raddr_i;
    end else if (sc_ded) begin
      ded_addr_d = ptr_q;
    end

    state_d     = state_q;
    timer_d     = timer_q;
    ptr_d       = ptr_q;
    sc_data_d   = sc_data_q;
    sc_status_d = sc_status_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (scrub_en_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (!scrub_en_i) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q == TimerW'(SCRUB_PERIOD - 1)) begin
          state_d = StRead;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StRead: begin
        sc_data_d   = sc_dec_data;
        sc_status_d = sc_dec_status;
        state_d     = StFix;
      end
      StFix: begin
        ptr_d   = ptr_q + AddrW'(1);
        state_d = scrub_en_i ? StWait : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q       <= '{default: '0};
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      rsec_q      <= 1'b0;
      rded_q      <= 1'b0;
      state_q     <= StIdle;
      timer_q     <= '0;
      ptr_q       <= '0;
      sc_data_q   <= '0;
      sc_status_q <= CLEAN;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
      ded_addr_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      rsec_q      <= rsec_d;
      rded_q      <= rded_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      ptr_q       <= ptr_d;
      sc_data_q   <= sc_data_d;
      sc_status_q <= sc_status_d;
      sec_cnt_q   <= sec_cnt_d;
      ded_cnt_q   <= ded_cnt_d;
      ded_addr_q  <= ded_addr_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign rsec_o       = rsec_q;
  assign rded_o       = rded_q;
  assign scrub_busy_o = (state_q == StRead) || (state_q == StFix);
  assign sec_cnt_o    = sec_cnt_q;
  assign ded_cnt_o    = ded_cnt_q;
  assign ded_addr_o   = ded_addr_q;

endmodule
